// File: rtl/ccu_clk_slice_ctrl.sv
// rtl/ccu_clk_slice_ctrl.sv - per-slice clock req/ack handshake with ramp delays, divided clock enable and sticky protocol errors
module ccu_clk_slice_ctrl #(
    parameter int NUM_SLICES = 4,
    parameter int DLYW       = 6,
    parameter int DIVW       = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [NUM_SLICES-1:0]      clk_req,
    input  logic [DLYW-1:0]            cfg_up_dly,
    input  logic [DLYW-1:0]            cfg_dn_dly,
    input  logic [NUM_SLICES*DIVW-1:0] cfg_div,
    input  logic                       err_clr,
    output logic [NUM_SLICES-1:0]      clk_ack,
    output logic [NUM_SLICES-1:0]      clk_en,
    output logic [NUM_SLICES-1:0]      slice_busy,
    output logic [NUM_SLICES-1:0]      err_protocol
);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_UP_WAIT = 2'd1,
        S_ON      = 2'd2,
        S_DN_WAIT = 2'd3
    } state_e;

    localparam logic [DLYW-1:0] DLY_ONE = DLYW'(1);
    localparam logic [DIVW-1:0] DIV_ONE = DIVW'(1);

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        state_e          state_q, state_d;
        logic [DLYW-1:0] dly_q, dly_d;
        logic [DIVW-1:0] div_cnt_q, div_cnt_d;
        logic [DIVW-1:0] div_q, div_d;
        logic            ack_q, ack_d;
        logic            en_q, en_d;
        logic            busy_q, busy_d;
        logic            err_q, err_d;
        logic            err_set;
        logic [DIVW-1:0] div_field;

        assign div_field = cfg_div[i*DIVW +: DIVW];

        always_comb begin
            state_d   = state_q;
            dly_d     = dly_q;
            div_cnt_d = div_cnt_q;
            div_d     = div_q;
            ack_d     = ack_q;
            en_d      = en_q;
            err_set   = 1'b0;
            case (state_q)
                S_OFF: begin
                    if (clk_req[i]) begin
                        state_d = S_UP_WAIT;
                        dly_d   = cfg_up_dly;
                    end
                end
                S_UP_WAIT: begin
                    // A dropped request is flagged but the ramp still completes.
                    err_set = ~clk_req[i];
                    if (dly_q == '0) begin
                        state_d   = S_ON;
                        ack_d     = 1'b1;
                        en_d      = 1'b1;
                        div_cnt_d = '0;
                        div_d     = div_field;
                    end else begin
                        dly_d = dly_q - DLY_ONE;
                    end
                end
                S_ON: begin
                    if (!clk_req[i]) begin
                        state_d = S_DN_WAIT;
                        dly_d   = cfg_dn_dly;
                        en_d    = 1'b0;
                    end else if (div_cnt_q == div_q) begin
                        // Ratio changes are only picked up at the period boundary.
                        div_cnt_d = '0;
                        div_d     = div_field;
                        en_d      = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_ONE;
                        en_d      = 1'b0;
                    end
                end
                S_DN_WAIT: begin
                    err_set = clk_req[i];
                    if (dly_q == '0) begin
                        state_d = S_OFF;
                        ack_d   = 1'b0;
                    end else begin
                        dly_d = dly_q - DLY_ONE;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    ack_d   = 1'b0;
                    en_d    = 1'b0;
                end
            endcase
            busy_d = (state_d == S_UP_WAIT) || (state_d == S_DN_WAIT);
            err_d  = err_set | (err_q & ~err_clr);
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state_q   <= S_OFF;
                dly_q     <= '0;
                div_cnt_q <= '0;
                div_q     <= '0;
                ack_q     <= 1'b0;
                en_q      <= 1'b0;
                busy_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                dly_q     <= dly_d;
                div_cnt_q <= div_cnt_d;
                div_q     <= div_d;
                ack_q     <= ack_d;
                en_q      <= en_d;
                busy_q    <= busy_d;
                err_q     <= err_d;
            end
        end

        assign clk_ack[i]      = ack_q;
        assign clk_en[i]       = en_q;
        assign slice_busy[i]   = busy_q;
        assign err_protocol[i] = err_q;
    end

endmodule

// File: tb/tb_ccu_clk_slice_ctrl.sv
// tb/tb_ccu_clk_slice_ctrl.sv - self-checking bench for ccu_clk_slice_ctrl against a timestamp-based reference model
module tb_ccu_clk_slice_ctrl;

    localparam int M_OFF  = 0;
    localparam int M_RISE = 1;
    localparam int M_ON   = 2;
    localparam int M_FALL = 3;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [3:0]  clk_req;
    logic [5:0]  cfg_up_dly;
    logic [5:0]  cfg_dn_dly;
    logic [15:0] cfg_div;
    logic        err_clr;
    logic [3:0]  clk_ack;
    logic [3:0]  clk_en;
    logic [3:0]  slice_busy;
    logic [3:0]  err_protocol;

    int checks   = 0;
    int failures = 0;

    // Reference model: absolute cycle timestamps for ack edges and enable pulses.
    int         n;
    int         m_mode   [4];
    int         m_target [4];
    int         m_next   [4];
    logic [3:0] m_ack, m_en, m_busy, m_err;

    ccu_clk_slice_ctrl #(.NUM_SLICES(4), .DLYW(6), .DIVW(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .clk_req      (clk_req),
        .cfg_up_dly   (cfg_up_dly),
        .cfg_dn_dly   (cfg_dn_dly),
        .cfg_div      (cfg_div),
        .err_clr      (err_clr),
        .clk_ack      (clk_ack),
        .clk_en       (clk_en),
        .slice_busy   (slice_busy),
        .err_protocol (err_protocol)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_vec();
        return {clk_ack, clk_en, slice_busy, err_protocol};
    endfunction

    function automatic logic [15:0] mdl_vec();
        return {m_ack, m_en, m_busy, m_err};
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i]   = M_OFF;
            m_target[i] = 0;
            m_next[i]   = 0;
        end
        m_ack  = '0;
        m_en   = '0;
        m_busy = '0;
        m_err  = '0;
    endtask

    task automatic model_step();
        logic s;
        n++;
        for (int i = 0; i < 4; i++) begin
            s = 1'b0;
            case (m_mode[i])
                M_OFF: begin
                    if (clk_req[i]) begin
                        m_mode[i]   = M_RISE;
                        m_target[i] = n + int'(cfg_up_dly) + 1;
                        m_busy[i]   = 1'b1;
                    end
                end
                M_RISE: begin
                    s = !clk_req[i];
                    if (n == m_target[i]) begin
                        m_mode[i] = M_ON;
                        m_ack[i]  = 1'b1;
                        m_en[i]   = 1'b1;
                        m_next[i] = n + int'(cfg_div[i*4 +: 4]) + 1;
                        m_busy[i] = 1'b0;
                    end
                end
                M_ON: begin
                    if (!clk_req[i]) begin
                        m_mode[i]   = M_FALL;
                        m_target[i] = n + int'(cfg_dn_dly) + 1;
                        m_en[i]     = 1'b0;
                        m_busy[i]   = 1'b1;
                    end else begin
                        m_en[i] = (n == m_next[i]);
                        if (m_en[i]) m_next[i] = n + int'(cfg_div[i*4 +: 4]) + 1;
                    end
                end
                M_FALL: begin
                    s = clk_req[i];
                    if (n == m_target[i]) begin
                        m_mode[i] = M_OFF;
                        m_ack[i]  = 1'b0;
                        m_busy[i] = 1'b0;
                    end
                end
                default: m_mode[i] = M_OFF;
            endcase
            m_err[i] = s | (m_err[i] & ~err_clr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_all_off();
        int k;
        clk_req = '0;
        err_clr = 1'b0;
        k = 0;
        while (k < 200 && (m_ack != 0 || m_busy != 0)) begin
            tick();
            k++;
        end
        checks++;
        if (clk_ack !== 4'h0 || slice_busy !== 4'h0) begin
            failures++;
            $display("FAIL wait_all_off: ack=%h busy=%h required 0 within 200 cycles", clk_ack, slice_busy);
        end
    endtask

    task automatic test_reset();
        rst_b      = 1'b0;
        clk_req    = 4'hF;
        cfg_up_dly = 6'd3;
        cfg_dn_dly = 6'd3;
        cfg_div    = '0;
        err_clr    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0000", dut_vec());
        end
        rst_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (clk_ack !== ((k >= 5) ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL reset_ack_latency: tick %0d ack=%h required %h", k, clk_ack, (k >= 5) ? 4'hF : 4'h0);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL reset_model: tick %0d got %h required %h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_divider();
        int k;
        wait_all_off();
        cfg_up_dly = 6'd0;
        cfg_div    = 16'h0002;
        clk_req    = 4'h1;
        k = 0;
        while (k < 10 && clk_ack[0] !== 1'b1) begin
            tick();
            k++;
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (clk_en[0] !== ((c < 15) ? (c % 3 == 0) : 1'b1)) begin
                failures++;
                $display("FAIL divider_pattern: on-cycle %0d en=%b required %b", c, clk_en[0], (c < 15) ? (c % 3 == 0) : 1'b1);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL divider_model: on-cycle %0d got %h required %h", c, dut_vec(), mdl_vec());
            end
            if (c == 13) cfg_div = 16'h0000;
            tick();
        end
    endtask

    task automatic test_zero_delay();
        logic [3:0] exp_busy [4];
        logic [3:0] exp_ack  [4];
        wait_all_off();
        cfg_up_dly = 6'd0;
        cfg_dn_dly = 6'd0;
        exp_busy[0] = 4'h2; exp_ack[0] = 4'h0;
        exp_busy[1] = 4'h0; exp_ack[1] = 4'h2;
        exp_busy[2] = 4'h2; exp_ack[2] = 4'h2;
        exp_busy[3] = 4'h0; exp_ack[3] = 4'h0;
        clk_req = 4'h2;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) clk_req = 4'h0;
            tick();
            checks++;
            if (slice_busy !== exp_busy[k] || clk_ack !== exp_ack[k]) begin
                failures++;
                $display("FAIL zero_delay: step %0d busy=%h ack=%h required busy=%h ack=%h", k, slice_busy, clk_ack, exp_busy[k], exp_ack[k]);
            end
        end
    endtask

    task automatic test_protocol();
        wait_all_off();
        err_clr = 1'b1;
        tick();
        err_clr    = 1'b0;
        cfg_up_dly = 6'd5;
        cfg_dn_dly = 6'd3;
        clk_req    = 4'h4;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) clk_req = 4'h0;
            checks++;
            if (clk_ack[2] !== (k >= 7) || slice_busy[2] !== (k != 7) || err_protocol[2] !== (k >= 3)) begin
                failures++;
                $display("FAIL protocol_updrop: tick %0d ack=%b busy=%b err=%b required ack=%b busy=%b err=%b",
                         k, clk_ack[2], slice_busy[2], err_protocol[2], k >= 7, k != 7, k >= 3);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL protocol_model: tick %0d got %h required %h", k, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_err_clr();
        wait_all_off();
        cfg_up_dly = 6'd5;
        clk_req    = 4'h2;
        tick();
        clk_req = 4'h0;
        err_clr = 1'b1;
        tick();
        checks++;
        if (err_protocol !== 4'h2) begin
            failures++;
            $display("FAIL err_clr_set_wins: err=%h required 2", err_protocol);
        end
        clk_req = 4'h2;
        err_clr = 1'b0;
        tick();
        checks++;
        if (err_protocol !== 4'h2 || dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL err_clr_sticky: got %h required %h (err 2)", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) clk_req[i] = ~clk_req[i];
            cfg_up_dly = 6'($urandom_range(0, 7));
            cfg_dn_dly = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) cfg_div = 16'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_model: cycle %0d got %h required %h", k, dut_vec(), mdl_vec());
                bad++;
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        int k;
        wait_all_off();
        cfg_up_dly = 6'd0;
        cfg_dn_dly = 6'd30;
        cfg_div    = 16'h1111;
        clk_req    = 4'hF;
        k = 0;
        while (k < 10 && clk_ack !== 4'hF) begin
            tick();
            k++;
        end
        clk_req = 4'h0;
        tick();
        tick();
        clk_req = 4'hF;
        tick();
        clk_req = 4'h0;
        tick();
        checks++;
        if (dut_vec() !== mdl_vec() || slice_busy !== 4'hF || err_protocol !== 4'hF) begin
            failures++;
            $display("FAIL async_pre_reset: got %h required %h with busy/err F", dut_vec(), mdl_vec());
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 16'h0) begin
            failures++;
            $display("FAIL async_reset_immediate: got %h required 0000", dut_vec());
        end
        model_reset();
        @(negedge clk);
        rst_b      = 1'b1;
        cfg_up_dly = 6'd2;
        clk_req    = 4'hF;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL async_post_reset: tick %0d got %h required %h", j, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_zero_delay();
        test_protocol();
        test_err_clr();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
